pixel_blink_period_meter: RTL and testbench
===========================================

Name: pixel_blink_period_meter

Overview:
Upstream measurement stage for frequency_analyzer_manager. It taps one pixel (fixed index within each line) from the 8-bit pixel stream and thresholds it into bright or dark. It measures the pixel_clock period between debounced dark-to-bright transitions and emits one period word per blink cycle. The manager converts that word to frequency and compares it against its PIXELn_FREQUENCYm windows.

Parameters:
PIXEL_INDEX, 2, index (0-based from line_start) of the tapped pixel
INDEX_WIDTH, 12, width of the in-line pixel index counter
THRESHOLD_VALUE, 100, data >= this is bright, otherwise dark
DARK_PIXELS_COUNT, 32, consecutive dark samples required to re-arm edge detection
COUNTER_WIDTH, 32, period counter and period output width

Ports:
pixel_clock  in  1  sole clock
reset  in  1  synchronous, active-high
data  in  8  pixel value, valid every pixel_clock
line_start  in  1  high on the cycle carrying pixel index 0
start  in  1  one-cycle pulse, arm measurement
stop  in  1  one-cycle pulse, halt measurement
period  out  COUNTER_WIDTH  measured cycles between qualifying edges
period_valid  out  1  one-cycle strobe, period is new
overflow  out  1  sticky, period counter saturated
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, pixel_clock. reset is synchronous and active-high. On reset: state=IDLE, index=0, counters=0, period=0, period_valid=0, overflow=0, busy=0. Reset mid-operation aborts with no strobe.
- Index counter: set to 0 on a line_start cycle. Otherwise it increments and saturates at 2^INDEX_WIDTH-1 (no wrap).
- Sample cycle: index==PIXEL_INDEX, including the line_start cycle when PIXEL_INDEX=0.
- Bright test: data >= THRESHOLD_VALUE, evaluated on the sample cycle only. Data on all other cycles is ignored.
- dark_cnt: counts consecutive dark samples and saturates at DARK_PIXELS_COUNT. A bright sample clears it. armed = (dark_cnt == DARK_PIXELS_COUNT).
- States:
  - IDLE: start -> WAIT_DARK; clears dark_cnt, period counter and overflow.
  - WAIT_DARK: armed -> WAIT_EDGE.
  - WAIT_EDGE: bright sample -> MEASURE; period counter := 0; dark_cnt := 0 (reference edge).
  - MEASURE: counter +1 every cycle. On a bright sample while armed:
    - period := counter+1, i.e. the exact cycle distance between the two sample cycles.
    - period_valid=1 on the next cycle, for 1 cycle.
    - counter := 0, dark_cnt := 0; stay in MEASURE (this edge is the next reference).
  - MEASURE: a bright sample while not armed clears dark_cnt and produces no output; the counter continues.
  - MEASURE overflow: counter reaching 2^COUNTER_WIDTH-1 sets overflow=1 (sticky) and goes to WAIT_DARK with no strobe.
- Control priority:
  - stop, from any state: -> IDLE next cycle. An edge in the same cycle produces no strobe. period holds its last value.
  - start while busy: restart as from IDLE.
  - start and stop in the same cycle: stop wins.
- Outputs are registered; latency from the qualifying sample cycle to period_valid is 1 cycle.
- period holds its value between strobes.
- busy = 1 in every state except IDLE.

Decomposition:
- Package pixel_meter_pkg:
  - state enum {IDLE, WAIT_DARK, WAIT_EDGE, MEASURE}
  - default widths
  - DARK_CNT_WIDTH = $clog2(DARK_PIXELS_COUNT+1)
- Sub-module pixel_tap_sampler: index counter plus threshold compare. Outputs sample_valid and sample_bright, combinational from the registered index. The FSM and counters stay in the top module.

Test Plan:
1. Setup: PIXEL_INDEX=2, line_start every 8 clocks, DARK_PIXELS_COUNT=2. Pixel 2 = 200 on every 4th line, 10 otherwise; start pulse. -> The first bright sample is the reference; every following bright sample gives period_valid with period=32, exactly 1 cycle after the sample; busy=1 throughout.
2. Threshold boundary: pixel 2 data=100 is bright and data=99 is dark. Alternate 100/99 each 4-line block -> period=64.
3. Index isolation: index 3 = 255 and pixel 2 = 10 constantly -> period_valid never asserts; state stays WAIT_EDGE.
4. Debounce: bright, dark, bright (only one dark sample, DARK_PIXELS_COUNT=2), then 2 dark, then bright -> a single strobe, with period equal to the distance from the first bright to the last bright (40 with 8-clock lines).
5. Overflow: COUNTER_WIDTH=8, blink period 512 clocks -> overflow=1 and stays set, no period_valid, busy=1. A new start clears overflow.
6. Abort:
   - stop asserted on the qualifying sample cycle -> no period_valid; busy=0 next cycle; period unchanged.
   - reset mid-MEASURE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/pixel_meter_pkg.sv
// rtl/pixel_meter_pkg.sv - shared state encoding and default widths for the blink period meter
package pixel_meter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DARK = 2'd1,
        WAIT_EDGE = 2'd2,
        MEASURE   = 2'd3
    } state_t;

    localparam int DEF_PIXEL_INDEX       = 2;
    localparam int DEF_INDEX_WIDTH       = 12;
    localparam int DEF_THRESHOLD_VALUE   = 100;
    localparam int DEF_DARK_PIXELS_COUNT = 32;
    localparam int DEF_COUNTER_WIDTH     = 32;
    localparam int DARK_CNT_WIDTH        = $clog2(DEF_DARK_PIXELS_COUNT + 1);

endpackage

// File: rtl/pixel_tap_sampler.sv
// rtl/pixel_tap_sampler.sv - in-line pixel index counter and bright/dark threshold on the tapped pixel
module pixel_tap_sampler
    import pixel_meter_pkg::*;
#(
    parameter int PIXEL_INDEX     = DEF_PIXEL_INDEX,
    parameter int INDEX_WIDTH     = DEF_INDEX_WIDTH,
    parameter int THRESHOLD_VALUE = DEF_THRESHOLD_VALUE
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       line_start,
    output logic       sample_valid,
    output logic       sample_bright
);

    localparam logic [INDEX_WIDTH-1:0] IDX_MAX = '1;
    localparam logic [INDEX_WIDTH-1:0] TAP     = INDEX_WIDTH'(PIXEL_INDEX);

    logic [INDEX_WIDTH-1:0] index_q;
    logic [INDEX_WIDTH-1:0] index_d;
    logic [INDEX_WIDTH-1:0] cur_index;

    // index_q holds the index of the current cycle unless line_start forces it to 0
    always_comb begin
        cur_index = line_start ? '0 : index_q;
        index_d   = (cur_index == IDX_MAX) ? IDX_MAX : cur_index + INDEX_WIDTH'(1);
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign sample_valid  = (cur_index == TAP);
    assign sample_bright = sample_valid && (data >= 8'(THRESHOLD_VALUE));

endmodule

// File: rtl/pixel_blink_period_meter.sv
// rtl/pixel_blink_period_meter.sv - measures clocks between debounced dark-to-bright edges of one pixel
module pixel_blink_period_meter
    import pixel_meter_pkg::*;
#(
    parameter int PIXEL_INDEX       = DEF_PIXEL_INDEX,
    parameter int INDEX_WIDTH       = DEF_INDEX_WIDTH,
    parameter int THRESHOLD_VALUE   = DEF_THRESHOLD_VALUE,
    parameter int DARK_PIXELS_COUNT = DEF_DARK_PIXELS_COUNT,
    parameter int COUNTER_WIDTH     = DEF_COUNTER_WIDTH
) (
    input  logic                     pixel_clock,
    input  logic                     reset,
    input  logic [7:0]               data,
    input  logic                     line_start,
    input  logic                     start,
    input  logic                     stop,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic                     period_valid,
    output logic                     overflow,
    output logic                     busy
);

    localparam int DCW = $clog2(DARK_PIXELS_COUNT + 1);
    localparam logic [DCW-1:0]           DARK_MAX = DCW'(DARK_PIXELS_COUNT);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;

    logic sample_valid;
    logic sample_bright;

    pixel_tap_sampler #(
        .PIXEL_INDEX     (PIXEL_INDEX),
        .INDEX_WIDTH     (INDEX_WIDTH),
        .THRESHOLD_VALUE (THRESHOLD_VALUE)
    ) u_sampler (
        .pixel_clock   (pixel_clock),
        .reset         (reset),
        .data          (data),
        .line_start    (line_start),
        .sample_valid  (sample_valid),
        .sample_bright (sample_bright)
    );

    state_t                   state_q, state_d;
    logic [DCW-1:0]           dark_q, dark_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d;
    logic                     pv_q, pv_d;
    logic                     ovf_q, ovf_d;
    logic                     armed;

    assign armed = (dark_q == DARK_MAX);

    always_comb begin
        state_d  = state_q;
        dark_d   = dark_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        ovf_d    = ovf_q;

        if (sample_valid) begin
            dark_d = sample_bright ? '0 : (armed ? dark_q : dark_q + DCW'(1));
        end

        case (state_q)
            WAIT_DARK: begin
                if (armed) state_d = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                if (sample_bright) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                // saturation beats a coincident edge: the distance no longer fits
                if (cnt_q == CNT_MAX) begin
                    ovf_d   = 1'b1;
                    state_d = WAIT_DARK;
                end else if (sample_bright && armed) begin
                    period_d = cnt_q + COUNTER_WIDTH'(1);
                    pv_d     = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                end
            end
            default: ;
        endcase

        if (stop) begin
            state_d  = IDLE;
            pv_d     = 1'b0;
            period_d = period_q;
        end else if (start) begin
            state_d  = WAIT_DARK;
            dark_d   = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            pv_d     = 1'b0;
            period_d = period_q;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q  <= IDLE;
            dark_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dark_q   <= dark_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            ovf_q    <= ovf_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_blink_period_meter.sv
// tb/tb_pixel_blink_period_meter.sv - directed bench for the pixel blink period meter
module tb_pixel_blink_period_meter;

    logic        pixel_clock = 1'b0;
    logic        reset       = 1'b1;
    logic        line_start  = 1'b0;
    logic        start       = 1'b0;
    logic        stop        = 1'b0;
    logic [7:0]  data        = 8'd0;

    logic [31:0] period;
    logic        period_valid, overflow, busy;
    logic [7:0]  period_ov;
    logic        period_valid_ov, overflow_ov, busy_ov;

    int n_cmp  = 0;
    int n_fail = 0;

    int          pv_cnt, pv_k, ov_pv_cnt;
    logic [31:0] pv_per;
    logic        busy_at2;

    pixel_blink_period_meter #(
        .PIXEL_INDEX(2), .INDEX_WIDTH(12), .THRESHOLD_VALUE(100),
        .DARK_PIXELS_COUNT(2), .COUNTER_WIDTH(32)
    ) dut (
        .pixel_clock(pixel_clock), .reset(reset), .data(data), .line_start(line_start),
        .start(start), .stop(stop), .period(period), .period_valid(period_valid),
        .overflow(overflow), .busy(busy)
    );

    pixel_blink_period_meter #(
        .PIXEL_INDEX(2), .INDEX_WIDTH(12), .THRESHOLD_VALUE(100),
        .DARK_PIXELS_COUNT(2), .COUNTER_WIDTH(8)
    ) dut_ov (
        .pixel_clock(pixel_clock), .reset(reset), .data(data), .line_start(line_start),
        .start(start), .stop(stop), .period(period_ov), .period_valid(period_valid_ov),
        .overflow(overflow_ov), .busy(busy_ov)
    );

    always #5 pixel_clock = ~pixel_clock;

    // One 8-clock line; pixel 2 carries v2, pixel 3 carries v3, stop optionally on the pixel 2 cycle
    task automatic run_line(input logic [7:0] v2, input logic [7:0] v3, input bit stop_at2);
        pv_cnt    = 0;
        pv_k      = -1;
        ov_pv_cnt = 0;
        pv_per    = '0;
        busy_at2  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            line_start = (k == 0);
            data       = (k == 2) ? v2 : ((k == 3) ? v3 : 8'd0);
            stop       = stop_at2 && (k == 2);
            @(posedge pixel_clock);
            #1;
            stop = 1'b0;
            if (period_valid) begin
                pv_cnt++;
                pv_k   = k;
                pv_per = period;
            end
            if (period_valid_ov) ov_pv_cnt++;
            if (k == 2) busy_at2 = busy;
        end
        line_start = 1'b0;
    endtask

    task automatic pulse_start();
        line_start = 1'b0;
        data       = 8'd0;
        start      = 1'b1;
        @(posedge pixel_clock);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge pixel_clock);
        #1;
        n_cmp++;
        if ({period, period_valid, overflow, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_dut: got period=%0d pv=%b ovf=%b busy=%b, want all 0",
                     period, period_valid, overflow, busy);
        end
        n_cmp++;
        if ({period_ov, period_valid_ov, overflow_ov, busy_ov} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_dut_ov: got period=%0d pv=%b ovf=%b busy=%b, want all 0",
                     period_ov, period_valid_ov, overflow_ov, busy_ov);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit exp;
        pulse_start();
        repeat (3) run_line(8'd10, 8'd0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            run_line((i % 4 == 0) ? 8'd200 : 8'd10, 8'd0, 1'b0);
            exp = (i % 4 == 0) && (i > 0);
            n_cmp++;
            if (pv_cnt !== (exp ? 1 : 0)) begin
                n_fail++;
                $display("FAIL basic_strobes line %0d: got %0d, want %0d", i, pv_cnt, exp ? 1 : 0);
            end
            if (exp) begin
                n_cmp++;
                if (pv_per !== 32'd32 || pv_k !== 2) begin
                    n_fail++;
                    $display("FAIL basic_period line %0d: got period=%0d at k=%0d, want 32 at k=2",
                             i, pv_per, pv_k);
                end
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_busy line %0d: got %b, want 1", i, busy);
            end
        end
    endtask

    task automatic test_threshold();
        bit exp;
        pulse_start();
        repeat (3) run_line(8'd99, 8'd0, 1'b0);
        for (int i = 0; i < 28; i++) begin
            run_line(((i / 4) % 2 == 0) ? 8'd100 : 8'd99, 8'd0, 1'b0);
            exp = (i % 8 == 0) && (i > 0);
            n_cmp++;
            if (pv_cnt !== (exp ? 1 : 0)) begin
                n_fail++;
                $display("FAIL threshold_strobes line %0d: got %0d, want %0d", i, pv_cnt, exp ? 1 : 0);
            end
            if (exp) begin
                n_cmp++;
                if (pv_per !== 32'd64) begin
                    n_fail++;
                    $display("FAIL threshold_period line %0d: got %0d, want 64", i, pv_per);
                end
            end
        end
    endtask

    task automatic test_index_isolation();
        int total;
        total = 0;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            run_line(8'd10, 8'd255, 1'b0);
            total += pv_cnt;
        end
        n_cmp++;
        if (total !== 0) begin
            n_fail++;
            $display("FAIL index_isolation_strobes: got %0d, want 0", total);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL index_isolation_busy: got %b, want 1", busy);
        end
    endtask

    task automatic test_debounce();
        logic [7:0] pat [6];
        int early;
        pat = '{8'd200, 8'd10, 8'd200, 8'd10, 8'd10, 8'd200};
        early = 0;
        pulse_start();
        repeat (3) run_line(8'd10, 8'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_line(pat[i], 8'd0, 1'b0);
            if (i < 5) early += pv_cnt;
        end
        n_cmp++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL debounce_early_strobes: got %0d, want 0", early);
        end
        n_cmp++;
        if (pv_cnt !== 1 || pv_per !== 32'd40) begin
            n_fail++;
            $display("FAIL debounce_period: got %0d strobes period=%0d, want 1 strobe period=40",
                     pv_cnt, pv_per);
        end
    endtask

    task automatic test_overflow();
        int ov_total;
        ov_total = 0;
        pulse_start();
        repeat (3) run_line(8'd10, 8'd0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            run_line(8'd200, 8'd0, 1'b0);
            ov_total += ov_pv_cnt;
            if (b > 0) begin
                n_cmp++;
                if (pv_cnt !== 1 || pv_per !== 32'd512) begin
                    n_fail++;
                    $display("FAIL overflow_wide_period blink %0d: got %0d strobes period=%0d, want 1 at 512",
                             b, pv_cnt, pv_per);
                end
            end
            for (int i = 0; i < 63; i++) begin
                run_line(8'd10, 8'd0, 1'b0);
                ov_total += ov_pv_cnt;
                if (b == 0 && i == 29) begin
                    n_cmp++;
                    if (overflow_ov !== 1'b0) begin
                        n_fail++;
                        $display("FAIL overflow_early: got %b, want 0", overflow_ov);
                    end
                end
            end
            n_cmp++;
            if (overflow_ov !== 1'b1 || busy_ov !== 1'b1) begin
                n_fail++;
                $display("FAIL overflow_sticky blink %0d: got ovf=%b busy=%b, want 1 1",
                         b, overflow_ov, busy_ov);
            end
        end
        n_cmp++;
        if (ov_total !== 0) begin
            n_fail++;
            $display("FAIL overflow_no_strobe: got %0d, want 0", ov_total);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_wide_clear: got %b, want 0", overflow);
        end
        pulse_start();
        n_cmp++;
        if (overflow_ov !== 1'b0 || busy_ov !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_restart: got ovf=%b busy=%b, want 0 1", overflow_ov, busy_ov);
        end
    endtask

    task automatic test_abort();
        pulse_start();
        repeat (3) run_line(8'd10, 8'd0, 1'b0);
        run_line(8'd200, 8'd0, 1'b0);
        repeat (3) run_line(8'd10, 8'd0, 1'b0);
        run_line(8'd200, 8'd0, 1'b1);
        n_cmp++;
        if (pv_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_stop_strobe: got %0d, want 0", pv_cnt);
        end
        n_cmp++;
        if (busy_at2 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop_busy: got %b, want 0", busy_at2);
        end
        n_cmp++;
        if (period !== 32'd512) begin
            n_fail++;
            $display("FAIL abort_stop_period: got %0d, want 512", period);
        end

        pulse_start();
        repeat (3) run_line(8'd10, 8'd0, 1'b0);
        run_line(8'd200, 8'd0, 1'b0);
        repeat (2) run_line(8'd10, 8'd0, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_reset_busy: got %b, want 1", busy);
        end
        reset = 1'b1;
        @(posedge pixel_clock);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({period, period_valid, overflow, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL abort_reset: got period=%0d pv=%b ovf=%b busy=%b, want all 0",
                     period, period_valid, overflow, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_index_isolation();
        test_debounce();
        test_overflow();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
